// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller for the accumulator CPU datapath.
// Owns the program counter, fetches instructions over a req/ack handshake,
// decodes the opcode and emits one-cycle write strobes to the datapath.
// Sequencing adds JUMP/JZ/HALT so the PC is no longer a free-running counter.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, the core parks in PAUSE after every EXECUTE and waits for a
//   `step` sample before fetching the next instruction.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   run          in   start from IDLE / resume from HALTED
//   step         in   (SINGLE_STEP_EN only) advance one instruction from PAUSE
//   fetchReq     out  instruction fetch request
//   fetchAddr    out  fetch address (= PC)
//   fetchAck     in   fetchData valid this cycle
//   fetchData    in   instruction word
//   accZero      in   accumulator == 0, sampled in EXECUTE
//   instruction  out  latched current instruction
//   accWrite     out  ADD strobe
//   reg1Write    out  MOVE strobe
//   loadImm      out  LOADI strobe
//   accClear     out  RESET strobe
//   halted       out  core is in HALTED
module pc_sequencer #(
  parameter int unsigned COUNTER_WIDTH     = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 11,
  parameter int unsigned OPCODE_WIDTH      = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
`ifdef SINGLE_STEP_EN
  input  logic                         step,
`endif
  output logic                         fetchReq,
  output logic [COUNTER_WIDTH-1:0]     fetchAddr,
  input  logic                         fetchAck,
  input  logic [INSTRUCTION_WIDTH-1:0] fetchData,
  input  logic                         accZero,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         accWrite,
  output logic                         reg1Write,
  output logic                         loadImm,
  output logic                         accClear,
  output logic                         halted
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVE  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOADI = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_RESET = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(7);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXECUTE,
    HALTED
`ifdef SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] pc;
  logic [OPCODE_WIDTH-1:0]  data_op;
  logic [OPCODE_WIDTH-1:0]  exec_op;
  logic [COUNTER_WIDTH-1:0] target;
  logic [COUNTER_WIDTH-1:0] pc_inc;

  // Opcode of the incoming word drives the strobe, so it is high during EXECUTE
  assign data_op   = fetchData[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign exec_op   = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign target    = instruction[COUNTER_WIDTH-1:0];
  assign pc_inc    = pc + COUNTER_WIDTH'(1);
  assign fetchAddr = pc;

  // Sequencer: state, PC, latched instruction and registered strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      fetchReq    <= 1'b0;
      accWrite    <= 1'b0;
      reg1Write   <= 1'b0;
      loadImm     <= 1'b0;
      accClear    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      accWrite  <= 1'b0;
      reg1Write <= 1'b0;
      loadImm   <= 1'b0;
      accClear  <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            fetchReq <= 1'b1;
          end
        end
        FETCH: begin
          if (fetchAck) begin
            instruction <= fetchData;
            fetchReq    <= 1'b0;
            state       <= EXECUTE;
            accWrite    <= (data_op == OP_ADD);
            reg1Write   <= (data_op == OP_MOVE);
            loadImm     <= (data_op == OP_LOADI);
            accClear    <= (data_op == OP_RESET);
          end
        end
        EXECUTE: begin
          case (exec_op)
            OP_JUMP:  pc <= target;
            OP_JZ:    pc <= accZero ? target : pc_inc;
            OP_RESET: pc <= '0;
            default:  pc <= pc_inc;
          endcase
          if (exec_op == OP_HALT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
`ifdef SINGLE_STEP_EN
            state    <= PAUSE;
`else
            state    <= FETCH;
            fetchReq <= 1'b1;
`endif
          end
        end
        HALTED: begin
          if (run) begin
            halted   <= 1'b0;
            state    <= FETCH;
            fetchReq <= 1'b1;
          end
        end
`ifdef SINGLE_STEP_EN
        PAUSE: begin
          if (step) begin
            state    <= FETCH;
            fetchReq <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          fetchReq <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed program table, random
// instruction stream against an instruction-level PC model, and reset-in-fetch.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic        fetchReq;
  logic [7:0]  fetchAddr;
  logic        fetchAck;
  logic [10:0] fetchData;
  logic        accZero;
  logic [10:0] instruction;
  logic        accWrite;
  logic        reg1Write;
  logic        loadImm;
  logic        accClear;
  logic        halted;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .fetchReq    (fetchReq),
    .fetchAddr   (fetchAddr),
    .fetchAck    (fetchAck),
    .fetchData   (fetchData),
    .accZero     (accZero),
    .instruction (instruction),
    .accWrite    (accWrite),
    .reg1Write   (reg1Write),
    .loadImm     (loadImm),
    .accClear    (accClear),
    .halted      (halted)
  );

  typedef struct {
    logic [10:0] instr;
    int unsigned w;
    logic        az;
    logic [7:0]  addr;
    logic [3:0]  strb;
    logic        halt;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [3:0] strb_now();
    return {accWrite, reg1Write, loadImm, accClear};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction: hold the request for w cycles, ack, check EXECUTE, then the follow-up state
  task automatic apply(input logic [10:0] instr, input int unsigned w, input logic az,
                       input logic [7:0] addr, input logic [3:0] strb, input logic halt_exp);
    for (int i = 0; i < int'(w); i++) begin
      check("wait_req", 32'(fetchReq), 32'd1);
      check("wait_addr", 32'(fetchAddr), 32'(addr));
      check("wait_strb", 32'(strb_now()), 32'd0);
      @(negedge clock);
    end
    check("req", 32'(fetchReq), 32'd1);
    check("addr", 32'(fetchAddr), 32'(addr));
    fetchAck  = 1'b1;
    fetchData = instr;
    @(negedge clock);
    fetchAck  = 1'b0;
    fetchData = 11'($urandom);
    check("strobe", 32'(strb_now()), 32'(strb));
    check("instruction", 32'(instruction), 32'(instr));
    check("exec_req", 32'(fetchReq), 32'd0);
    accZero = az;
    @(negedge clock);
    check("strobe_off", 32'(strb_now()), 32'd0);
    if (halt_exp) begin
      check("halted", 32'(halted), 32'd1);
      check("halt_req", 32'(fetchReq), 32'd0);
      fetchAck = 1'b1;
      repeat (2) begin
        @(negedge clock);
        check("halt_hold", 32'({halted, fetchReq}), 32'd2);
      end
      fetchAck = 1'b0;
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      check("resume", 32'({halted, fetchReq}), 32'd1);
    end else begin
`ifdef SINGLE_STEP_EN
      check("pause_req", 32'(fetchReq), 32'd0);
      run      = 1'b1;
      fetchAck = 1'b1;
      @(negedge clock);
      run      = 1'b0;
      fetchAck = 1'b0;
      check("pause_hold", 32'({halted, fetchReq}), 32'd0);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
`endif
      check("next_req", 32'({halted, fetchReq}), 32'd1);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [2:0] op);
    case (op)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [10:0] instr,
                                            input logic az);
    case (instr[10:8])
      3'd5:    return instr[7:0];
      3'd6:    return az ? instr[7:0] : 8'(pc + 8'd1);
      3'd4:    return 8'd0;
      default: return 8'(pc + 8'd1);
    endcase
  endfunction

  initial begin
    logic [7:0]  pc;
    logic [10:0] w;
    logic        az;

    tbl[0]  = '{11'h305, 0, 1'b0, 8'h00, 4'b0010, 1'b0};
    tbl[1]  = '{11'h100, 0, 1'b0, 8'h01, 4'b1000, 1'b0};
    tbl[2]  = '{11'h200, 3, 1'b0, 8'h02, 4'b0100, 1'b0};
    tbl[3]  = '{11'h610, 0, 1'b1, 8'h03, 4'b0000, 1'b0};
    tbl[4]  = '{11'h640, 1, 1'b0, 8'h10, 4'b0000, 1'b0};
    tbl[5]  = '{11'h5FF, 0, 1'b0, 8'h11, 4'b0000, 1'b0};
    tbl[6]  = '{11'h000, 0, 1'b0, 8'hFF, 4'b0000, 1'b0};
    tbl[7]  = '{11'h400, 1, 1'b1, 8'h00, 4'b0001, 1'b0};
    tbl[8]  = '{11'h503, 0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[9]  = '{11'h700, 0, 1'b0, 8'h03, 4'b0000, 1'b1};
    tbl[10] = '{11'h000, 0, 1'b0, 8'h04, 4'b0000, 1'b0};

    reset     = 1'b0;
    run       = 1'b0;
    step      = 1'b0;
    fetchAck  = 1'b0;
    fetchData = '0;
    accZero   = 1'b0;
    #12;
    check("rst_req", 32'(fetchReq), 32'd0);
    check("rst_addr", 32'(fetchAddr), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_strb", 32'(strb_now()), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_req", 32'(fetchReq), 32'd0);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;

    foreach (tbl[i])
      apply(tbl[i].instr, tbl[i].w, tbl[i].az, tbl[i].addr, tbl[i].strb, tbl[i].halt);

    // Random instruction stream against the instruction-level PC model
    pc = 8'h05;
    for (int n = 0; n < 200; n++) begin
      w  = 11'($urandom);
      az = 1'($urandom);
      apply(w, $urandom_range(0, 3), az, pc, model_strb(w[10:8]), w[10:8] == 3'd7);
      pc = model_next(pc, w, az);
    end

    // Reset asserted while a fetch is waiting on its ack
    @(negedge clock);
    check("pre_rst_req", 32'(fetchReq), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_req", 32'(fetchReq), 32'd0);
    check("midrst_addr", 32'(fetchAddr), 32'd0);
    check("midrst_instr", 32'(instruction), 32'd0);
    fetchAck  = 1'b1;
    fetchData = 11'h305;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("postrst_req", 32'(fetchReq), 32'd0);
      check("postrst_instr", 32'(instruction), 32'd0);
      check("postrst_strb", 32'(strb_now()), 32'd0);
    end
    fetchAck = 1'b0;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    apply(11'h100, 0, 1'b0, 8'h00, 4'b1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
